// File: rtl/ray_plane_hit_pipe_if.sv
// Request/response bus for the ray/plane intersection block.
// master = requester side, slave = the intersection block.
interface ray_plane_hit_pipe_if #(
  parameter int WIDTH = 32
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] normal0, normal1, normal2;
  logic signed [WIDTH-1:0] origin0, origin1, origin2;
  logic signed [WIDTH-1:0] v0_0, v0_1, v0_2;
  logic signed [WIDTH-1:0] dir0, dir1, dir2;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] p_hit0, p_hit1, p_hit2;
  logic signed [WIDTH-1:0] t_hit;
  logic                    parallel;
  logic                    behind;

  modport master (
    output in_valid, normal0, normal1, normal2, origin0, origin1, origin2,
           v0_0, v0_1, v0_2, dir0, dir1, dir2, out_ready,
    input  in_ready, out_valid, p_hit0, p_hit1, p_hit2, t_hit, parallel, behind
  );

  modport slave (
    input  in_valid, normal0, normal1, normal2, origin0, origin1, origin2,
           v0_0, v0_1, v0_2, dir0, dir1, dir2, out_ready,
    output in_ready, out_valid, p_hit0, p_hit1, p_hit2, t_hit, parallel, behind
  );
endinterface

// File: rtl/ray_plane_hit_pipe.sv
// Ray/plane intersection in signed fixed point:
//   t = n.(v0 - o) / n.d  (serial restoring divide), p = o + d*t.
module ray_plane_hit_pipe #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  ray_plane_hit_pipe_if.slave bus
);

  localparam int               CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] POS_MAX  = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {S_IDLE, S_DOT, S_DIV, S_SCALE, S_DONE} state_t;
  state_t state_q, state_d;

  // Captured request
  logic [WIDTH-1:0] nrm_q [3];
  logic [WIDTH-1:0] org_q [3];
  logic [WIDTH-1:0] pnt_q [3];
  logic [WIDTH-1:0] dir_q [3];

  // Divider state
  logic [WIDTH-1:0] rem_q, dvd_q, quot_q, den_mag_q;
  logic             sign_q, ovf_q, par_q;
  logic [CW-1:0]    cnt_q;

  // Result registers
  logic [WIDTH-1:0] p_hit_q [3];
  logic [WIDTH-1:0] t_hit_q;
  logic             parallel_q, behind_q;
  logic             in_ready_o, out_valid_o;

  // Bus inputs gathered as arrays
  logic [WIDTH-1:0] nrm_i [3];
  logic [WIDTH-1:0] org_i [3];
  logic [WIDTH-1:0] pnt_i [3];
  logic [WIDTH-1:0] dir_i [3];

  assign nrm_i[0] = bus.normal0;  assign nrm_i[1] = bus.normal1;  assign nrm_i[2] = bus.normal2;
  assign org_i[0] = bus.origin0;  assign org_i[1] = bus.origin1;  assign org_i[2] = bus.origin2;
  assign pnt_i[0] = bus.v0_0;     assign pnt_i[1] = bus.v0_1;     assign pnt_i[2] = bus.v0_2;
  assign dir_i[0] = bus.dir0;     assign dir_i[1] = bus.dir1;     assign dir_i[2] = bus.dir2;

  // Combinational datapath
  logic [2*WIDTH-1:0] prod_v [3];
  logic [2*WIDTH-1:0] prod_o [3];
  logic [2*WIDTH-1:0] prod_d [3];
  logic [2*WIDTH-1:0] prod_s [3];
  logic [WIDTH-1:0]   dot_v, dot_o, den_c, num_c, num_mag, den_mag, t_mag, t_c;
  logic [WIDTH-1:0]   p_c [3];
  logic               par_c, ovf_c, div_ge;
  logic [WIDTH:0]     rem_sh, rem_nx;
  logic               unused_bits;

  // Full signed product of two WIDTH-bit words
  function automatic logic [2*WIDTH-1:0] smul(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    return {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  endfunction

  // Dot products and divider setup. Only the low WIDTH bits of the wide sum
  // survive, so summing the WIDTH-bit slices of each shifted product is exact.
  always_comb begin
    dot_v = '0;
    dot_o = '0;
    den_c = '0;
    for (int i = 0; i < 3; i++) begin
      prod_v[i] = smul(nrm_q[i], pnt_q[i]);
      prod_o[i] = smul(nrm_q[i], org_q[i]);
      prod_d[i] = smul(nrm_q[i], dir_q[i]);
      dot_v = dot_v + prod_v[i][FRAC +: WIDTH];
      dot_o = dot_o + prod_o[i][FRAC +: WIDTH];
      den_c = den_c + prod_d[i][FRAC +: WIDTH];
    end
    num_c   = dot_v - dot_o;
    par_c   = (den_c == '0);
    num_mag = num_c[WIDTH-1] ? -num_c : num_c;
    den_mag = den_c[WIDTH-1] ? -den_c : den_c;
    // Dividend bits above the WIDTH quotient bits already >= divisor means
    // the quotient cannot fit in WIDTH bits.
    ovf_c   = (num_mag >> (WIDTH - FRAC)) >= den_mag;
  end

  // One restoring-division step
  always_comb begin
    rem_sh = {rem_q, dvd_q[WIDTH-1]};
    div_ge = rem_sh >= {1'b0, den_mag_q};
    rem_nx = div_ge ? (rem_sh - {1'b0, den_mag_q}) : rem_sh;
  end

  // Saturated, signed t and the scaled hit point
  always_comb begin
    t_mag = (ovf_q || quot_q[WIDTH-1]) ? POS_MAX : quot_q;
    t_c   = sign_q ? -t_mag : t_mag;
    for (int i = 0; i < 3; i++) begin
      prod_s[i] = smul(dir_q[i], t_c);
      p_c[i]    = org_q[i] + prod_s[i][FRAC +: WIDTH];
    end
  end

  // Fold the product bits that truncation intentionally drops
  always_comb begin
    unused_bits = rem_nx[WIDTH];
    for (int i = 0; i < 3; i++) begin
      unused_bits = unused_bits ^ (^prod_v[i]) ^ (^prod_o[i]) ^ (^prod_d[i]) ^ (^prod_s[i]);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = S_DOT;
      S_DOT:   state_d = par_c ? S_SCALE : S_DIV;
      S_DIV:   if (cnt_q == CNT_LAST) state_d = S_SCALE;
      S_SCALE: state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready_o  = (state_q == S_IDLE);
    out_valid_o = (state_q == S_DONE);
  end

  // Datapath registers: capture, divider setup, divide steps, result load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        nrm_q[i]   <= '0;
        org_q[i]   <= '0;
        pnt_q[i]   <= '0;
        dir_q[i]   <= '0;
        p_hit_q[i] <= '0;
      end
      rem_q      <= '0;
      dvd_q      <= '0;
      quot_q     <= '0;
      den_mag_q  <= '0;
      sign_q     <= 1'b0;
      ovf_q      <= 1'b0;
      par_q      <= 1'b0;
      cnt_q      <= '0;
      t_hit_q    <= '0;
      parallel_q <= 1'b0;
      behind_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            for (int i = 0; i < 3; i++) begin
              nrm_q[i] <= nrm_i[i];
              org_q[i] <= org_i[i];
              pnt_q[i] <= pnt_i[i];
              dir_q[i] <= dir_i[i];
            end
          end
        end
        S_DOT: begin
          // A parallel ray leaves quotient zero so t comes out as 0
          quot_q    <= '0;
          den_mag_q <= den_mag;
          rem_q     <= par_c ? '0 : (num_mag >> (WIDTH - FRAC));
          dvd_q     <= num_mag << FRAC;
          sign_q    <= num_c[WIDTH-1] ^ den_c[WIDTH-1];
          ovf_q     <= ~par_c & ovf_c;
          par_q     <= par_c;
          cnt_q     <= '0;
        end
        S_DIV: begin
          rem_q  <= rem_nx[WIDTH-1:0];
          dvd_q  <= dvd_q << 1;
          quot_q <= {quot_q[WIDTH-2:0], div_ge};
          cnt_q  <= cnt_q + CNT_ONE;
        end
        S_SCALE: begin
          for (int i = 0; i < 3; i++) p_hit_q[i] <= p_c[i];
          t_hit_q    <= t_c;
          parallel_q <= par_q;
          behind_q   <= t_c[WIDTH-1] & ~par_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_o;
  assign bus.out_valid = out_valid_o;
  assign bus.p_hit0    = p_hit_q[0];
  assign bus.p_hit1    = p_hit_q[1];
  assign bus.p_hit2    = p_hit_q[2];
  assign bus.t_hit     = t_hit_q;
  assign bus.parallel  = parallel_q;
  assign bus.behind    = behind_q;

endmodule

// File: doc/ray_plane_hit_pipe.md
RAY_PLANE_HIT_PIPE -- requirements
Module: ray_plane_hit_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the signed fixed-point word width of every vector component.
REQ-002 The block SHALL have parameter FRAC, default 16, giving the fraction bits per word (Q(WIDTH-FRAC).FRAC); legal range 1..WIDTH-2.
REQ-003 Port clk, input, 1, the single rising-edge clock.
REQ-004 Port reset_n, input, 1, asynchronous active-low reset.
REQ-005 Port in_valid, input, 1, request present on the input bus.
REQ-006 Port in_ready, output, 1, block can accept a request.
REQ-007 Ports normal0..2, origin0..2, v0_0..2, dir0..2, input, WIDTH each, signed plane normal, ray origin, plane point and ray direction.
REQ-008 Port out_valid, output, 1, result present.
REQ-009 Port out_ready, input, 1, downstream accepts the result.
REQ-010 Ports p_hit0..2, output, WIDTH each, signed hit point.
REQ-011 Port t_hit, output, WIDTH, signed ray parameter.
REQ-012 Port parallel, output, 1, the ray is parallel to the plane (denominator zero).
REQ-013 Port behind, output, 1, t_hit is negative.

Function
REQ-014 The FSM SHALL have states IDLE, DOT, DIV, SCALE and DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 In IDLE, in_valid=1 SHALL capture all 12 inputs into registers and move to DOT; later input changes SHALL have no effect until the block returns to IDLE.
REQ-016 In DOT (1 cycle), each dot product SHALL be the sum of the three products a_i*b_i, each arithmetic-shifted right by FRAC, accumulated at 2*WIDTH+2 bits and truncated to WIDTH; num = n.v0 - n.origin (WIDTH, wraps); den = n.dir.
REQ-017 From DOT, den==0 SHALL go directly to SCALE with t=0 and parallel=1; otherwise the FSM SHALL go to DIV.
REQ-018 DIV SHALL be a restoring divider on magnitudes, one quotient bit per cycle, for exactly WIDTH cycles, computing |num|<<FRAC / |den|, truncated toward zero.
REQ-019 The quotient sign SHALL be sign(num) XOR sign(den); a magnitude above 2^(WIDTH-1)-1 SHALL saturate to +max or -max (never the most negative value).
REQ-020 In SCALE (1 cycle), p_hit_i SHALL be origin_i + ((dir_i*t) >>> FRAC), with the product at 2*WIDTH bits and the sum truncated to WIDTH (wraps); for parallel=1 this gives p_hit = origin.
REQ-021 behind SHALL be t[WIDTH-1], and SHALL be 0 when parallel=1.
REQ-022 In DONE, out_valid SHALL be 1 and all outputs SHALL be stable.
REQ-023 out_valid and out_ready both 1 on a rising edge SHALL return the FSM to IDLE.
REQ-024 A held out_ready=0 SHALL hold DONE and all outputs indefinitely.
REQ-025 Latency from the input handshake edge to out_valid SHALL be WIDTH+3 cycles (35 at default), or 3 cycles when den==0; throughput is one request per latency plus one cycle.
REQ-026 in_ready SHALL be 0 in DONE, so a new request is never accepted in the same cycle as the output handshake.

Reset
REQ-027 Asserting reset_n=0 SHALL asynchronously force state IDLE, in_ready=1, out_valid=0, and p_hit0..2, t_hit, parallel and behind to 0.
REQ-028 Reset mid-operation (DOT, DIV, SCALE or DONE) SHALL discard the request with no output handshake.
REQ-029 After reset_n rises, the first clock edge SHALL be able to accept a request.

Verification (WIDTH=32, FRAC=16)
REQ-030 Inputs n=(0,0,0x10000), o=0, v0=(0,0,0x50000), dir=(0,0,0x10000) SHALL give t=0x50000, p_hit=(0,0,0x50000), parallel=0, behind=0, and out_valid exactly 35 cycles after the handshake.
REQ-031 Inputs n=(0,0,0x10000), dir=(0x10000,0,0) SHALL give parallel=1, t=0, p_hit=origin, and out_valid 3 cycles after the handshake.
REQ-032 Inputs n=(0,0,0x10000), o=(0,0,0x50000), v0=0, dir=(0,0,0x10000) SHALL give t=0xFFFB0000 (-5.0), behind=1, p_hit=(0,0,0).
REQ-033 Inputs num=0x7FFF0000 with den=0x1 SHALL give t=0x7FFFFFFF (saturated).
REQ-034 Holding out_ready=0 for 10 cycles in DONE SHALL keep the outputs stable and in_ready=0; releasing it SHALL return to IDLE on the next edge.
REQ-035 Pulsing reset_n low during DIV SHALL immediately give out_valid=0 and in_ready=1, and the next request SHALL produce a correct result.
